// File: rtl/color_pkg.sv
// Shared FSM encoding, default sizing and small helpers for the colour sensor array controller.
package color_pkg;

    localparam int unsigned N_CH_DEF    = 2;
    localparam int unsigned DATA_W_DEF  = 16;
    localparam int unsigned PWM_W_DEF   = 8;
    localparam int unsigned TIMEOUT_DEF = 2**24;

    localparam int unsigned ST_W = 3;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_TRIG    = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_HOLD    = 3'd4;

    // A zero auto period behaves as a single idle cycle.
    function automatic logic [31:0] eff_period(input logic [31:0] p);
        return (p == 32'd0) ? 32'd1 : p;
    endfunction

endpackage

// File: rtl/color_chan_pwm.sv
// One channel's sample-to-duty scaling and the three colour PWM comparators.
module color_chan_pwm
    import color_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned PWM_W  = PWM_W_DEF
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [PWM_W-1:0]  pwm_cnt,
    input  logic              pwm_wrap,
    input  logic              valid,
    input  logic [3:0]        shift,
    input  logic              invert,
    input  logic [DATA_W-1:0] red,
    input  logic [DATA_W-1:0] green,
    input  logic [DATA_W-1:0] blue,
    output logic              led_r,
    output logic              led_g,
    output logic              led_b
);

    localparam int unsigned EXT_W = ((DATA_W > PWM_W) ? DATA_W : PWM_W) + 1;
    localparam logic [PWM_W-1:0] DUTY_MAX = '1;

    logic [PWM_W-1:0] duty_r;
    logic [PWM_W-1:0] duty_g;
    logic [PWM_W-1:0] duty_b;

    function automatic logic [PWM_W-1:0] scale(input logic [DATA_W-1:0] smp, input logic [3:0] sh);
        logic [EXT_W-1:0] ext;
        ext = EXT_W'(smp) >> sh;
        return (ext > EXT_W'(DUTY_MAX)) ? DUTY_MAX : ext[PWM_W-1:0];
    endfunction

    // Duties only move at the counter wrap so a period is never cut short.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            duty_r <= '0;
            duty_g <= '0;
            duty_b <= '0;
        end else if (pwm_wrap) begin
            duty_r <= valid ? scale(red, shift)   : '0;
            duty_g <= valid ? scale(green, shift) : '0;
            duty_b <= valid ? scale(blue, shift)  : '0;
        end
    end

    // Left combinational on invert so the LEDs follow invert even while held in reset.
    assign led_r = (pwm_cnt < duty_r) ^ invert;
    assign led_g = (pwm_cnt < duty_g) ^ invert;
    assign led_b = (pwm_cnt < duty_b) ^ invert;

endmodule

// File: rtl/color_array_ctrl.sv
// Scan controller for an array of RGB colour sensors driving one PWM RGB LED per channel.
module color_array_ctrl
    import color_pkg::*;
#(
    parameter int unsigned N_CH    = N_CH_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned PWM_W   = PWM_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   measure_req,
    input  logic                   auto_en,
    input  logic [31:0]            auto_period,
    input  logic [3:0]             shift,
    input  logic [N_CH-1:0]        invert,
    output logic [N_CH-1:0]        meas_o,
    input  logic [N_CH-1:0]        ready_i,
    input  logic [N_CH*DATA_W-1:0] red_i,
    input  logic [N_CH*DATA_W-1:0] green_i,
    input  logic [N_CH*DATA_W-1:0] blue_i,
    output logic [N_CH-1:0]        led_r,
    output logic [N_CH-1:0]        led_g,
    output logic [N_CH-1:0]        led_b,
    output logic [N_CH-1:0]        valid,
    output logic [N_CH-1:0]        err,
    output logic                   busy
);

    localparam int unsigned TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned BUS_W = N_CH * DATA_W;

    logic [ST_W-1:0]  state;
    logic [ST_W-1:0]  state_nxt;
    logic             req_q;
    logic             auto_q;
    logic [N_CH-1:0]  done;
    logic [N_CH-1:0]  seen_low;
    logic [N_CH-1:0]  hit;
    logic [N_CH-1:0]  done_nxt;
    logic [TO_W-1:0]  tcnt;
    logic [31:0]      hcnt;
    logic [BUS_W-1:0] lat_r, lat_g, lat_b;
    logic [BUS_W-1:0] smp_r, smp_g, smp_b;
    logic [PWM_W-1:0] pwm_cnt;
    logic             pwm_wrap;

    // A channel completes on its first ready after having been seen low since the trigger.
    assign hit      = ready_i & seen_low & ~done;
    assign done_nxt = done | hit;
    assign pwm_wrap = (pwm_cnt == '1);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if ((measure_req && !req_q) || (auto_en && !auto_q)) state_nxt = ST_TRIG;
            ST_TRIG:    state_nxt = ST_WAIT;
            ST_WAIT:    if ((&done_nxt) || (tcnt == TO_W'(TIMEOUT - 1))) state_nxt = ST_CAPTURE;
            ST_CAPTURE: state_nxt = auto_en ? ST_HOLD : ST_IDLE;
            ST_HOLD: begin
                if (!auto_en)                                         state_nxt = ST_IDLE;
                else if (hcnt >= eff_period(auto_period) - 32'd1)     state_nxt = ST_TRIG;
            end
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Scan bookkeeping, shadow capture and result publication.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            req_q    <= 1'b0;
            auto_q   <= 1'b0;
            meas_o   <= '0;
            busy     <= 1'b0;
            done     <= '0;
            seen_low <= '0;
            tcnt     <= '0;
            hcnt     <= '0;
            valid    <= '0;
            err      <= '0;
            lat_r    <= '0;
            lat_g    <= '0;
            lat_b    <= '0;
            smp_r    <= '0;
            smp_g    <= '0;
            smp_b    <= '0;
        end else begin
            req_q  <= measure_req;
            auto_q <= auto_en;
            meas_o <= {N_CH{state_nxt == ST_TRIG}};
            busy   <= (state_nxt != ST_IDLE);
            case (state)
                ST_TRIG: begin
                    done     <= '0;
                    seen_low <= ~ready_i;
                    tcnt     <= '0;
                end
                ST_WAIT: begin
                    done     <= done_nxt;
                    seen_low <= seen_low | ~ready_i;
                    tcnt     <= tcnt + TO_W'(1);
                    for (int k = 0; k < N_CH; k++) begin
                        if (hit[k]) begin
                            lat_r[k*DATA_W +: DATA_W] <= red_i[k*DATA_W +: DATA_W];
                            lat_g[k*DATA_W +: DATA_W] <= green_i[k*DATA_W +: DATA_W];
                            lat_b[k*DATA_W +: DATA_W] <= blue_i[k*DATA_W +: DATA_W];
                        end
                    end
                end
                ST_CAPTURE: begin
                    hcnt  <= '0;
                    valid <= valid | done;
                    err   <= ~done;
                    for (int k = 0; k < N_CH; k++) begin
                        if (done[k]) begin
                            smp_r[k*DATA_W +: DATA_W] <= lat_r[k*DATA_W +: DATA_W];
                            smp_g[k*DATA_W +: DATA_W] <= lat_g[k*DATA_W +: DATA_W];
                            smp_b[k*DATA_W +: DATA_W] <= lat_b[k*DATA_W +: DATA_W];
                        end
                    end
                end
                ST_HOLD: hcnt <= hcnt + 32'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) pwm_cnt <= '0;
        else       pwm_cnt <= pwm_cnt + PWM_W'(1);
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_chan
        color_chan_pwm #(
            .DATA_W (DATA_W),
            .PWM_W  (PWM_W)
        ) u_chan (
            .clk      (clk),
            .nrst     (nrst),
            .pwm_cnt  (pwm_cnt),
            .pwm_wrap (pwm_wrap),
            .valid    (valid[k]),
            .shift    (shift),
            .invert   (invert[k]),
            .red      (smp_r[k*DATA_W +: DATA_W]),
            .green    (smp_g[k*DATA_W +: DATA_W]),
            .blue     (smp_b[k*DATA_W +: DATA_W]),
            .led_r    (led_r[k]),
            .led_g    (led_g[k]),
            .led_b    (led_b[k])
        );
    end

endmodule

// File: doc/color_array_ctrl.md
COLOR_ARRAY_CTRL -- requirements
Module: color_array_ctrl

Interface
REQ-001 SHALL have parameter N_CH, default 2, number of colour sensor channels (1..8).
REQ-002 SHALL have parameter DATA_W, default 16, sensor sample width per colour.
REQ-003 SHALL have parameter PWM_W, default 8, LED duty and PWM counter width.
REQ-004 SHALL have parameter TIMEOUT, default 2**24, cycles to wait for sensor ready before flagging error.
REQ-005 SHALL have ports: clk  in  1  sole clock; all logic on rising edge.
REQ-006 SHALL have ports: nrst  in  1  asynchronous active-low reset.
REQ-007 SHALL have ports: measure_req  in  1  level request, already debounced; rising edge starts one scan.
REQ-008 SHALL have ports: auto_en  in  1  continuous-scan mode enable.
REQ-009 SHALL have ports: auto_period  in  32  idle cycles between auto scans.
REQ-010 SHALL have ports: shift  in  4  right-shift applied to samples before PWM scaling.
REQ-011 SHALL have ports: invert  in  N_CH  per-channel complement of LED outputs.
REQ-012 SHALL have ports: meas_o  out  N_CH  one-cycle measure pulse to each sensor interface.
REQ-013 SHALL have ports: ready_i  in  N_CH  sensor ready levels.
REQ-014 SHALL have ports: red_i, green_i, blue_i  in  N_CH*DATA_W each  sensor samples; channel k at bits [k*DATA_W +: DATA_W].
REQ-015 SHALL have ports: led_r, led_g, led_b  out  N_CH each  PWM LED drives.
REQ-016 SHALL have ports: valid  out  N_CH  channel holds data from a completed scan.
REQ-017 SHALL have ports: err  out  N_CH  channel timed out on the last scan.
REQ-018 SHALL have ports: busy  out  1  scan in progress.

Function
REQ-019 SHALL implement FSM IDLE -> TRIG -> WAIT -> CAPTURE -> IDLE (auto_en=1: CAPTURE -> HOLD -> TRIG after auto_period cycles).
REQ-020 IDLE SHALL go to TRIG on rising edge of measure_req or auto_en rising; other edges ignored while busy.
REQ-021 TRIG SHALL assert meas_o all ones for exactly one cycle, clear per-channel done flags and the timeout counter.
REQ-022 WAIT SHALL set channel k done on first cycle ready_i[k] is 1 after having been 0 since TRIG, latching that channel's samples that same cycle.
REQ-023 WAIT SHALL exit to CAPTURE when all channels done or timeout counter reaches TIMEOUT-1.
REQ-024 CAPTURE (one cycle) SHALL set valid[k]=1, err[k]=0 for done channels; err[k]=1 and valid[k], samples unchanged for undone channels.
REQ-025 HOLD SHALL count auto_period cycles; auto_en=0 in HOLD returns to IDLE next cycle; auto_period=0 treated as 1.
REQ-026 busy SHALL be 1 in TRIG, WAIT, CAPTURE, HOLD.
REQ-027 Duty per colour SHALL be (sample >> shift) saturated to 2**PWM_W-1.
REQ-028 A single free-running PWM_W-bit counter SHALL serve all channels; led = (counter < duty) XOR invert[k]; duty 0 never on, max duty off one cycle per period.
REQ-029 Duty registers SHALL update only at PWM counter wrap to avoid glitches; valid[k]=0 forces duty 0.
REQ-030 measure_req held high SHALL trigger only one scan.

Reset
REQ-031 nrst low SHALL asynchronously force state IDLE, meas_o 0, valid 0, err 0, busy 0, samples 0, duties 0, PWM counter 0.
REQ-032 LED outputs during reset SHALL equal invert (duty 0 XOR invert).
REQ-033 Reset mid-scan SHALL abandon the scan with no partial capture visible after release.

Structure
REQ-034 FSM state encoding and default parameter constants SHALL reside in shared package color_pkg.
REQ-035 Per-channel scaling plus three PWM comparators SHALL be sub-module color_chan_pwm, instantiated N_CH times via generate.

Verification
REQ-036 N_CH=2, shift=8, measure_req pulse, both sensors ready after 100 cycles with red=16'hFF00 -> meas_o=2'b11 one cycle, valid=2'b11, duty red=8'hFF.
REQ-037 Channel 1 never ready, TIMEOUT=1000 -> CAPTURE at cycle 1000 after TRIG, err=2'b10, valid[1] unchanged.
REQ-038 auto_en=1, auto_period=50 -> meas_o pulses repeat every (wait+52) cycles; auto_en=0 in HOLD -> IDLE, no further pulse.
REQ-039 shift=0, sample 16'h0300 -> duty 8'hFF saturation; sample 0 -> led 0, invert=1 -> led constant 1.
REQ-040 nrst low during WAIT -> all outputs reset values immediately; after release no meas_o until new request.
REQ-041 measure_req held high 1000 cycles -> exactly one scan.
